// File: rtl/rv_core_pkg.sv
// Shared RV32IC core definitions: default datapath widths, the x0 index
// and the writeback requester identifiers.
package rv_core_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // x0 is hard-wired to zero, so writes targeting it are swallowed.
  localparam int unsigned ADDR_ZERO = 0;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_LD = 1'b1
  } req_idx_e;

endpackage : rv_core_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: owns the priority pointer and produces the
// one-hot grant, suppressed entirely while the hazard unit holds.
module rr_arb2
  import rv_core_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic hold_i,
  input  logic advance_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  req_idx_e prio_q;
  req_idx_e prio_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= REQ_EX;
    end else begin
      prio_q <= prio_d;
    end
  end

  // The pointer only moves on an accepted transfer, so hold cycles leave it alone.
  always_comb begin
    prio_d = prio_q;
    if (advance_i) begin
      if (gnt0_o) begin
        prio_d = REQ_LD;
      end else if (gnt1_o) begin
        prio_d = REQ_EX;
      end
    end
  end

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!hold_i) begin
      case ({valid1_i, valid0_i})
        2'b01: gnt0_o = 1'b1;
        2'b10: gnt1_o = 1'b1;
        2'b11: begin
          if (prio_q == REQ_EX) begin
            gnt0_o = 1'b1;
          end else begin
            gnt1_o = 1'b1;
          end
        end
        default: begin
          gnt0_o = 1'b0;
          gnt1_o = 1'b0;
        end
      endcase
    end
  end

endmodule : rr_arb2

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between the execute and load/CSR
// writeback paths; outputs are registered and writes to x0 are dropped.
module rf_wport_arbiter
  import rv_core_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hold_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  logic              wrEn_q;
  logic              wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [ADDR_W-1:0] wrAddr_d;
  logic [DATA_W-1:0] wrData_q;
  logic [DATA_W-1:0] wrData_d;

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid0_i (req0_valid_i),
    .valid1_i (req1_valid_i),
    .hold_i   (hold_i),
    .advance_i(xfer),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  // Readies are forced low during reset so nothing is consumed that cannot be written.
  assign req0_ready_o = req0_valid_i & gnt0 & ~hold_i & rst_ni;
  assign req1_ready_o = req1_valid_i & gnt1 & ~hold_i & rst_ni;
  assign xfer         = req0_ready_o | req1_ready_o;

  always_comb begin
    selAddr = req0_addr_i;
    selData = req0_data_i;
    if (req1_ready_o) begin
      selAddr = req1_addr_i;
      selData = req1_data_i;
    end
  end

  // An x0 transfer is still consumed, but it leaves the write enable low.
  always_comb begin
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    if (xfer) begin
      wrEn_d   = (selAddr != ADDR_W'(ADDR_ZERO));
      wrAddr_d = selAddr;
      wrData_d = selData;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  assign wr_en_o   = wrEn_q;
  assign wr_addr_o = wrAddr_q;
  assign wr_data_o = wrData_q;

  oneReady : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req0_ready_o && req1_ready_o));

endmodule : rf_wport_arbiter
